hilo_muldiv_unit: RTL

//  Execute-stage consumer of the decoder's HI/LO control (HILO_en, isMulOrDiv, is_dataMovWrite).
//  - Owns the HI and LO registers.
//  - Performs MULT/MULTU as a one-cycle write; DIV/DIVU as a multi-cycle radix-2 restoring divide.
//  - Applies MTHI/MTLO writes; stalls the pipeline while a divide is in flight.

---
 rtl/hilo_muldiv_unit_pkg.sv | 23 ++
 rtl/hilo_muldiv_unit_div_core.sv | 68 ++++++
 rtl/hilo_muldiv_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, FSM states, default sizes.
package hilo_muldiv_unit_pkg;

   localparam int WIDTH_DEF      = 32;
   localparam int DIV_CYCLES_DEF = 32;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_DIV_RUN = 2'b01,
      ST_DIV_FIX = 2'b10
   } state_e;

   // funct[0] clear selects the signed flavour of both MULT and DIV.
   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/hilo_muldiv_unit_div_core.sv
// Unsigned radix-2 restoring divider: one shift-subtract per cycle over magnitude operands.
module div_radix2_core #(
   parameter int WIDTH      = 32,
   parameter int DIV_CYCLES = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             last,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

   logic             busy_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] dsr_q;
   logic [WIDTH:0]   trial;

   // Partial remainder stays below the divisor, so bit WIDTH of the trial is the borrow.
   assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dsr_q};
   assign last  = busy_q && (cnt_q == CNT_W'(DIV_CYCLES - 1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         quo_q  <= '0;
         rem_q  <= '0;
         dsr_q  <= '0;
      end else if (abort) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else if (start) begin
         busy_q <= 1'b1;
         cnt_q  <= '0;
         quo_q  <= dividend;
         rem_q  <= '0;
         dsr_q  <= divisor;
      end else if (busy_q) begin
         if (trial[WIDTH]) begin
            rem_q <= {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
         end else begin
            rem_q <= trial[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
         end
         if (last) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign busy      = busy_q;
   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner for the execute stage: one-cycle MULT/MULTU, multi-cycle DIV/DIVU, MTHI/MTLO.
// Define HILO_FWD_EN to forward the value being written onto hi_o/lo_o in the same cycle.
module hilo_muldiv_unit
   import hilo_muldiv_unit_pkg::*;
#(
   parameter int WIDTH      = WIDTH_DEF,
   parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             mt_we,
   input  logic [1:0]       hilo_en,
   input  logic [WIDTH-1:0] mt_data,
   input  logic             flush,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0]   a_raw_q;
   logic               q_neg_q, r_neg_q, b_zero_q;
   logic               core_start, core_abort, core_busy, core_last;
   logic [WIDTH-1:0]   core_q, core_r;
   logic               sgn;
   logic [WIDTH-1:0]   mag_a, mag_b, fix_lo, fix_hi;
   logic [2*WIDTH-1:0] ext_a, ext_b, prod;

   assign sgn   = op_is_signed(op);
   // Low 2W bits of the product of the extended operands equal the signed or unsigned product.
   assign ext_a = {{WIDTH{sgn & src_a[WIDTH-1]}}, src_a};
   assign ext_b = {{WIDTH{sgn & src_b[WIDTH-1]}}, src_b};
   assign prod  = ext_a * ext_b;
   assign mag_a = (sgn && src_a[WIDTH-1]) ? -src_a : src_a;
   assign mag_b = (sgn && src_b[WIDTH-1]) ? -src_b : src_b;

   // Divide-by-zero bypasses the sign fixes: LO all-ones, HI the untouched dividend.
   assign fix_lo = b_zero_q ? '1 : (q_neg_q ? -core_q : core_q);
   assign fix_hi = b_zero_q ? a_raw_q : (r_neg_q ? -core_r : core_r);

   div_radix2_core #(
      .WIDTH      (WIDTH),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_div_core (
      .clk       (clk),
      .resetn    (resetn),
      .start     (core_start),
      .abort     (core_abort),
      .dividend  (mag_a),
      .divisor   (mag_b),
      .busy      (core_busy),
      .last      (core_last),
      .quotient  (core_q),
      .remainder (core_r)
   );

   always_comb begin
      state_d    = state_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      stall      = 1'b0;
      done       = 1'b0;
      core_start = 1'b0;
      core_abort = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start && !flush) begin
               if (op[1]) begin
                  stall      = 1'b1;
                  core_start = 1'b1;
                  state_d    = ST_DIV_RUN;
               end else begin
                  {hi_d, lo_d} = prod;
               end
            end else if (mt_we && !start) begin
               if (hilo_en[1]) hi_d = mt_data;
               if (hilo_en[0]) lo_d = mt_data;
            end
         end
         ST_DIV_RUN: begin
            stall = 1'b1;
            if (flush) begin
               core_abort = 1'b1;
               state_d    = ST_IDLE;
            end else if (core_last) begin
               state_d = ST_DIV_FIX;
            end
         end
         ST_DIV_FIX: begin
            state_d = ST_IDLE;
            if (!flush) begin
               done = 1'b1;
               hi_d = fix_hi;
               lo_d = fix_lo;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         hi_q     <= '0;
         lo_q     <= '0;
         a_raw_q  <= '0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         b_zero_q <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         if (core_start) begin
            a_raw_q  <= src_a;
            q_neg_q  <= sgn & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            r_neg_q  <= sgn & src_a[WIDTH-1];
            b_zero_q <= (src_b == '0);
         end
      end
   end

`ifdef HILO_FWD_EN
   assign hi_o = hi_d;
   assign lo_o = lo_d;
`else
   assign hi_o = hi_q;
   assign lo_o = lo_q;
`endif

endmodule
